readback_serialiser: RTL

Parametrised readback serialiser: captures `N_CH` monitor readback channels of `DATA_W` bits each and presents them one word at a time to the UART transmitter. It uses the DAQ word handshake (`tx_data_ready` / `tx_data_loaded` / `tx_complete`) and is triggered last in the DAQ cycle. Beyond a fixed 14×7 readback block, it adds:
- a frozen snapshot per transfer, so all words come from the same instant;
- a per-channel enable mask, so disabled channels are skipped;
- an optional leading header word;
- an abort path when `tx_en` drops mid-transfer.

---
 rtl/readback_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/readback_serialiser.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/readback_pkg.sv
// Shared types and helpers for the DAQ readback serialiser.
package readback_pkg;

    localparam int unsigned RB_N_CH   = 14;
    localparam int unsigned RB_DATA_W = 7;

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StScan,
        StPresent,
        StDone
    } rb_state_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/readback_serialiser.sv
// Freezes N_CH readback channels and hands them one word at a time to the UART,
// skipping masked channels and optionally leading with a channel-count header.
module readback_serialiser
    import readback_pkg::*;
#(
    parameter int unsigned N_CH   = RB_N_CH,
    parameter int unsigned DATA_W = RB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   rb_bus,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic                     hdr_en,
    input  logic                     tx_en,
    input  logic                     tx_data_loaded,
    output logic                     tx_data_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_complete,
    output logic                     tx_abort
);

    localparam int unsigned IDX_W = clog2(N_CH + 1);
    localparam int unsigned BUS_W = N_CH * DATA_W;

    logic [BUS_W-1:0]  rb_s1;
    logic [BUS_W-1:0]  rb_s2;
    logic [BUS_W-1:0]  snap;
    logic [N_CH-1:0]   mask_q;
    logic              hdr_pend;
    logic              hdr_sel;
    logic              loaded_s;
    logic [IDX_W-1:0]  idx;
    rb_state_e         state;

    logic [BUS_W-1:0]  snap_shift;
    logic [N_CH-1:0]   mask_shift;
    logic              cur_en;
    logic [DATA_W-1:0] hdr_word;

    // Count wraps naturally, giving the truncated header when DATA_W is narrow.
    function automatic logic [DATA_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [DATA_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = cnt + DATA_W'(v[i]);
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_s1 <= '0;
            rb_s2 <= '0;
        end else begin
            rb_s1 <= rb_bus;
            rb_s2 <= rb_s1;
        end
    end

    sync_2ff u_loaded_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx_data_loaded),
        .q   (loaded_s)
    );

    // Shifting rather than indexing keeps idx == N_CH in range and yields zero there.
    always_comb begin
        snap_shift = snap >> (int'(idx) * DATA_W);
        mask_shift = mask_q >> idx;
        cur_en     = mask_shift[0];
        hdr_word   = popcount(mask_q);
        tx_data    = hdr_sel ? hdr_word : snap_shift[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            snap          <= '0;
            mask_q        <= '0;
            hdr_pend      <= 1'b0;
            hdr_sel       <= 1'b0;
            idx           <= '0;
            tx_data_ready <= 1'b0;
            tx_complete   <= 1'b0;
            tx_abort      <= 1'b0;
        end else begin
            tx_abort <= 1'b0;
            unique case (state)
                StIdle: begin
                    idx           <= '0;
                    hdr_sel       <= 1'b0;
                    tx_data_ready <= 1'b0;
                    tx_complete   <= 1'b0;
                    if (tx_en) begin
                        state <= StSnap;
                    end
                end
                StSnap: begin
                    if (!tx_en) begin
                        state    <= StIdle;
                        tx_abort <= 1'b1;
                        idx      <= '0;
                    end else begin
                        snap     <= rb_s2;
                        mask_q   <= ch_mask;
                        hdr_pend <= hdr_en;
                        state    <= StScan;
                    end
                end
                StScan: begin
                    if (!tx_en) begin
                        state         <= StIdle;
                        tx_abort      <= 1'b1;
                        tx_data_ready <= 1'b0;
                        hdr_pend      <= 1'b0;
                        idx           <= '0;
                    end else if (hdr_pend) begin
                        if (!loaded_s) begin
                            hdr_sel       <= 1'b1;
                            tx_data_ready <= 1'b1;
                            state         <= StPresent;
                        end
                    end else if (idx == IDX_W'(N_CH)) begin
                        tx_complete <= 1'b1;
                        state       <= StDone;
                    end else if (!cur_en) begin
                        idx <= idx + 1'b1;
                    end else if (!loaded_s) begin
                        tx_data_ready <= 1'b1;
                        state         <= StPresent;
                    end
                end
                StPresent: begin
                    if (!tx_en) begin
                        // Abort beats a coincident load: the word is not counted.
                        state         <= StIdle;
                        tx_abort      <= 1'b1;
                        tx_data_ready <= 1'b0;
                        hdr_pend      <= 1'b0;
                        hdr_sel       <= 1'b0;
                        idx           <= '0;
                    end else if (loaded_s) begin
                        tx_data_ready <= 1'b0;
                        state         <= StScan;
                        if (hdr_sel) begin
                            hdr_pend <= 1'b0;
                            hdr_sel  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                StDone: begin
                    tx_complete <= 1'b1;
                    if (!tx_en) begin
                        tx_complete <= 1'b0;
                        idx         <= '0;
                        state       <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
